ifu_prefetch: RTL and testbench
===============================

// Module: ifu_prefetch
// PURPOSE
//  Parametrised instruction fetch unit with in-order request/response memory port and DEPTH-entry prefetch queue.
//  Sits between instruction memory and DECODE; replaces single-register fetch with pipelined fetch.
//  Supports multiple outstanding requests, redirect (branch/jump) with flush and stale-response discard.
// PARAMETERS
//  XLEN      32     address / PC width
//  ILEN      32     instruction word width
//  DEPTH     4      prefetch queue entries; power of 2, >=2; also max in-flight requests
//  RESET_PC  0      fetch PC after reset
//  PC_STEP   4      PC increment per fetched instruction
// PORTS
//  clk            in   1     clock, all state updates on rising edge
//  reset          in   1     asynchronous, active-high reset
//  redirect_valid in   1     load new fetch PC this cycle (branch/jump taken)
//  redirect_pc    in   XLEN  target PC, sampled when redirect_valid=1
//  mem_req_valid  out  1     fetch request pending
//  mem_req_addr   out  XLEN  fetch address (= fetch_pc)
//  mem_req_ready  in   1     memory accepts request this cycle
//  mem_rsp_valid  in   1     response data valid (responses strictly in request order)
//  mem_rsp_data   in   ILEN  fetched instruction word
//  ir_valid       out  1     queue head holds a valid instruction
//  ir             out  ILEN  head instruction; 0 when ir_valid=0
//  ir_pc          out  XLEN  PC of head instruction; 0 when ir_valid=0
//  ir_ready       in   1     DECODE consumes head this cycle
// BEHAVIOUR
//  - Reset (async, any time): fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, outstanding=0, discard=0;
//    mem_req_valid=0, ir_valid=0, ir=0, ir_pc=0. Reset mid-transfer drops all in-flight state.
//  - State: fetch_pc, rsp_pc (PC of next kept response), count (0..DEPTH), outstanding (0..DEPTH,
//    incl. stale), discard (0..outstanding). Counters $clog2(DEPTH)+1 bits; no wrap permitted.
//  - Issue: mem_req_valid = !redirect_valid && (count + outstanding < DEPTH); mem_req_addr = fetch_pc.
//    req_fire = mem_req_valid & mem_req_ready -> fetch_pc += PC_STEP (mod 2^XLEN), outstanding++.
//    Addr held stable while valid & !ready; request may be withdrawn only by redirect.
//  - Response: rsp_fire = mem_rsp_valid && outstanding!=0 (valid with outstanding==0 ignored).
//    discard!=0: word dropped, discard--. Else push {rsp_pc, data} to tail, rsp_pc += PC_STEP.
//    Either case outstanding--. Queue never overflows (guaranteed by issue rule).
//  - Output: ir_valid = (count!=0), ir/ir_pc = head, registered; pop on ir_valid & ir_ready.
//    Min latency: request accepted cycle t, response cycle t+k -> ir_valid from cycle t+k+1.
//  - Push and pop same cycle: count unchanged; full queue with pop accepts no push until next cycle.
//  - Redirect (highest priority): queue flushed (count=0, ir_valid=0 next cycle), fetch_pc=redirect_pc,
//    rsp_pc=redirect_pc, discard = outstanding - rsp_fire (all in flight become stale);
//    no request issued in redirect cycle; a response in that cycle is dropped if stale;
//    pop in that cycle ignored. First request to redirect_pc at cycle t+1 earliest.
//  - Back-to-back redirects: last one wins; discard accumulates per rule above, saturates never
//    (bounded by DEPTH).
//  - fetch_pc/rsp_pc wrap 2^XLEN-PC_STEP -> 0 silently.
// TESTING
//  1 Reset, mem_req_ready=1, 1-cycle rsp, ir_ready=1 -> addrs 0,4,8,...; ir_pc 0,4,8 in order, ir = data.
//  2 ir_ready=0, DEPTH=4 -> exactly 4 requests (0..C), mem_req_valid=0 after; ir_ready=1 resumes at 0x10.
//  3 3 requests in flight (0,4,8), redirect_pc=0x100 -> 3 rsps dropped, next ir_pc=0x100, no 0/4/8 seen.
//  4 Redirect same cycle as req_fire and rsp_fire -> discard counts correctly; first kept ir_pc=target.
//  5 RESET_PC=0xFFFFFFF8 -> fetch addrs FFFFFFF8, FFFFFFFC, 0 (wrap).
//  6 Assert reset with 2 outstanding and 2 queued -> all outputs 0 immediately; refetch from RESET_PC.

Source files
------------

// File: rtl/ifu_prefetch.sv
// Purpose: pipelined instruction fetch with in-order memory port and DEPTH-entry prefetch queue.
// Latency: request accepted in cycle t, response in cycle t+k -> instruction at the queue head from cycle t+k+1.
// Backpressure: a request issues only while queued + in-flight < DEPTH; DECODE stalls the head with ir_ready=0.
module ifu_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [ILEN-1:0] mem_rsp_data,
    output logic            ir_valid,
    output logic [ILEN-1:0] ir,
    output logic [XLEN-1:0] ir_pc,
    input  logic            ir_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_discard;
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [XLEN-1:0] r_q_pc  [DEPTH];
    logic [ILEN-1:0] r_q_dat [DEPTH];

    logic [CW:0]     w_occupancy;
    logic            w_req_vld;
    logic            w_req_fire;
    logic            w_rsp_fire;
    logic            w_push;
    logic            w_pop;

    // Queued plus in-flight words bound the queue, so an accepted request always has a slot.
    assign w_occupancy = {1'b0, r_count} + {1'b0, r_outstanding};
    // Held low while reset is asserted so the port is quiet during an asynchronous reset.
    assign w_req_vld   = !reset && !redirect_valid && (w_occupancy < (CW+1)'(DEPTH));
    assign w_req_fire  = w_req_vld && mem_req_ready;
    // A response with nothing in flight is spurious and ignored.
    assign w_rsp_fire  = mem_rsp_valid && (r_outstanding != '0);
    // Stale words (issued before a redirect) are dropped; a redirect flushes anyway.
    assign w_push      = w_rsp_fire && (r_discard == '0) && !redirect_valid;
    assign w_pop       = (r_count != '0) && ir_ready && !redirect_valid;

    assign mem_req_valid = w_req_vld;
    assign mem_req_addr  = r_fetch_pc;
    assign ir_valid      = (r_count != '0);
    assign ir            = ir_valid ? r_q_dat[r_head] : '0;
    assign ir_pc         = ir_valid ? r_q_pc[r_head]  : '0;

    // Fetch and response PCs: redirect reloads both, otherwise each advances on its own fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
            r_rsp_pc   <= redirect_pc;
        end else begin
            if (w_req_fire) r_fetch_pc <= r_fetch_pc + XLEN'(PC_STEP);
            if (w_push)     r_rsp_pc   <= r_rsp_pc + XLEN'(PC_STEP);
        end
    end

    // In-flight and stale-response counters; on redirect every word still in flight becomes stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_fire);
            if (redirect_valid)
                r_discard <= r_outstanding - CW'(w_rsp_fire);
            else if (w_rsp_fire && (r_discard != '0))
                r_discard <= r_discard - CW'(1);
        end
    end

    // Queue occupancy and ring pointers; redirect empties the queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else if (redirect_valid) begin
            r_count <= '0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) r_tail <= r_tail + PW'(1);
            if (w_pop)  r_head <= r_head + PW'(1);
        end
    end

    // Queue storage; contents are only meaningful below r_count so no reset is needed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_tail]  <= r_rsp_pc;
            r_q_dat[r_tail] <= mem_rsp_data;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: directed vector table, reset-mid-transfer sequence,
// wrap-around check on a second instance, and a randomized run against a queue model.
module tb_ifu_prefetch;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_ready;

    logic        w_req_v;
    logic [31:0] w_req_a;
    logic        w_iv;
    logic [31:0] w_ir;
    logic [31:0] w_irpc;

    int n_vec = 0;
    int n_err = 0;

    ifu_prefetch dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc), .ir_ready(ir_ready)
    );

    ifu_prefetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .mem_req_valid(w_req_v), .mem_req_addr(w_req_a), .mem_req_ready(1'b1),
        .mem_rsp_valid(1'b0), .mem_rsp_data(32'h0),
        .ir_valid(w_iv), .ir(w_ir), .ir_pc(w_irpc), .ir_ready(1'b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        irr;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_ir;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] ep;
    } pend_t;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    function automatic vec_t mk(input logic redir, input logic [31:0] rpc, input logic rdy,
                                input logic rv, input logic [31:0] rd, input logic irr,
                                input logic e_rv, input logic [31:0] e_ra, input logic e_iv,
                                input logic [31:0] e_pc, input logic [31:0] e_ir);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.rv = rv; v.rd = rd; v.irr = irr;
        v.e_rv = e_rv; v.e_ra = e_ra; v.e_iv = e_iv; v.e_pc = e_pc; v.e_ir = e_ir;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic redir, input logic [31:0] rpc, input logic rdy,
                         input logic rv, input logic [31:0] rd, input logic irr);
        redirect_valid = redir; redirect_pc = rpc; mem_req_ready = rdy;
        mem_rsp_valid = rv; mem_rsp_data = rd; ir_ready = irr;
    endtask

    vec_t  vt [22];
    pend_t pend [$];
    logic [31:0] mq [$];

    initial begin
        logic [31:0] m_fetch;
        logic [31:0] epoch;
        logic        redir, rdy, rv, irr, e_iv, e_rv, keep;
        logic [31:0] rpc, rd;
        pend_t       front;

        // directed table from reset: fill with ir_ready=0, drain, then redirect with 3 in flight
        vt[0]  = mk(0, 0,     1, 0, 0,                1, 1, 32'h00,  0, 0,      0);
        vt[0].irr = 0;
        vt[1]  = mk(0, 0,     1, 1, memw(32'h00),     0, 1, 32'h04,  0, 0,      0);
        vt[2]  = mk(0, 0,     1, 1, memw(32'h04),     0, 1, 32'h08,  1, 32'h0,  memw(32'h0));
        vt[3]  = mk(0, 0,     1, 1, memw(32'h08),     0, 1, 32'h0C,  1, 32'h0,  memw(32'h0));
        vt[4]  = mk(0, 0,     1, 1, memw(32'h0C),     0, 0, 32'h10,  1, 32'h0,  memw(32'h0));
        vt[5]  = mk(0, 0,     1, 0, 0,                0, 0, 32'h10,  1, 32'h0,  memw(32'h0));
        vt[6]  = mk(0, 0,     1, 0, 0,                1, 0, 32'h10,  1, 32'h0,  memw(32'h0));
        vt[7]  = mk(0, 0,     1, 0, 0,                1, 1, 32'h10,  1, 32'h4,  memw(32'h4));
        vt[8]  = mk(0, 0,     1, 1, memw(32'h10),     1, 1, 32'h14,  1, 32'h8,  memw(32'h8));
        vt[9]  = mk(0, 0,     0, 1, memw(32'h14),     1, 1, 32'h18,  1, 32'hC,  memw(32'hC));
        vt[10] = mk(0, 0,     0, 0, 0,                1, 1, 32'h18,  1, 32'h10, memw(32'h10));
        vt[11] = mk(0, 0,     0, 0, 0,                1, 1, 32'h18,  1, 32'h14, memw(32'h14));
        vt[12] = mk(0, 0,     1, 0, 0,                1, 1, 32'h18,  0, 0,      0);
        vt[13] = mk(0, 0,     1, 0, 0,                1, 1, 32'h1C,  0, 0,      0);
        vt[14] = mk(0, 0,     1, 0, 0,                1, 1, 32'h20,  0, 0,      0);
        vt[15] = mk(1, 32'h100, 1, 1, memw(32'h18),   1, 0, 32'h24,  0, 0,      0);
        vt[16] = mk(0, 0,     0, 1, memw(32'h1C),     1, 1, 32'h100, 0, 0,      0);
        vt[17] = mk(0, 0,     1, 1, memw(32'h20),     1, 1, 32'h100, 0, 0,      0);
        vt[18] = mk(0, 0,     0, 1, memw(32'h100),    1, 1, 32'h104, 0, 0,      0);
        vt[19] = mk(0, 0,     0, 0, 0,                1, 1, 32'h104, 1, 32'h100, memw(32'h100));
        vt[20] = mk(0, 0,     0, 1, 32'hDEAD_BEEF,    1, 1, 32'h104, 0, 0,      0);
        vt[21] = mk(0, 0,     0, 0, 0,                1, 1, 32'h104, 0, 0,      0);

        reset = 1'b1;
        drive(0, 0, 1, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req_v", 32'(mem_req_valid), 0);
        chk("rst.addr",  mem_req_addr, 0);
        chk("rst.ir_v",  32'(ir_valid), 0);
        chk("rst.ir",    ir, 0);
        chk("rst.ir_pc", ir_pc, 0);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            drive(vt[i].redir, vt[i].rpc, vt[i].rdy, vt[i].rv, vt[i].rd, vt[i].irr);
            #3;
            chk($sformatf("row%0d.req_v", i), 32'(mem_req_valid), 32'(vt[i].e_rv));
            chk($sformatf("row%0d.addr", i),  mem_req_addr, vt[i].e_ra);
            chk($sformatf("row%0d.ir_v", i),  32'(ir_valid), 32'(vt[i].e_iv));
            chk($sformatf("row%0d.ir_pc", i), ir_pc, vt[i].e_pc);
            chk($sformatf("row%0d.ir", i),    ir, vt[i].e_ir);
            if (i < 5) begin
                chk($sformatf("wrap%0d.req_v", i), 32'(w_req_v), (i < 4) ? 32'd1 : 32'd0);
                chk($sformatf("wrap%0d.addr", i),  w_req_a, 32'hFFFF_FFF8 + 32'(4 * i));
            end
            @(posedge clk);
            #1;
        end

        // two words queued and two in flight, then asynchronous reset
        drive(0, 0, 1, 0, 0, 0);             @(posedge clk); #1;
        drive(0, 0, 1, 1, memw(32'h104), 0); @(posedge clk); #1;
        drive(0, 0, 1, 1, memw(32'h108), 0); @(posedge clk); #1;
        drive(0, 0, 1, 0, 0, 0);             @(posedge clk); #1;
        chk("pre_rst.ir_pc", ir_pc, 32'h104);
        chk("pre_rst.req_v", 32'(mem_req_valid), 0);
        reset = 1'b1;
        #1;
        chk("mid_rst.req_v", 32'(mem_req_valid), 0);
        chk("mid_rst.ir_v",  32'(ir_valid), 0);
        chk("mid_rst.ir",    ir, 0);
        chk("mid_rst.ir_pc", ir_pc, 0);
        chk("mid_rst.addr",  mem_req_addr, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 0, 0, 1, memw(32'h10C), 0);
        #3;
        chk("post_rst.req_v", 32'(mem_req_valid), 1);
        chk("post_rst.addr",  mem_req_addr, 0);
        @(posedge clk); #1;
        chk("post_rst.ignored", 32'(ir_valid), 0);
        drive(0, 0, 1, 0, 0, 0);             @(posedge clk); #1;
        drive(0, 0, 0, 1, memw(32'h0), 0);   @(posedge clk); #1;
        chk("refetch.ir_v",  32'(ir_valid), 1);
        chk("refetch.ir_pc", ir_pc, 0);
        chk("refetch.ir",    ir, memw(32'h0));

        // randomized run against a queue model of memory and prefetch buffer
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_fetch = 32'h0;
        epoch = 32'h0;
        pend.delete();
        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            redir = ($urandom_range(0, 99) < 6);
            rpc   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
            rdy   = ($urandom_range(0, 99) < 70);
            irr   = ($urandom_range(0, 99) < 60);
            if (pend.size() != 0) begin
                rv = ($urandom_range(0, 99) < 60);
                rd = memw(pend[0].addr);
            end else begin
                rv = ($urandom_range(0, 99) < 10);
                rd = $urandom();
            end
            drive(redir, rpc, rdy, rv, rd, irr);
            #3;
            e_iv = (mq.size() != 0);
            e_rv = !redir && (mq.size() + pend.size() < 4);
            chk("rnd.ir_v",  32'(ir_valid), 32'(e_iv));
            chk("rnd.ir_pc", ir_pc, e_iv ? mq[0] : 32'h0);
            chk("rnd.ir",    ir, e_iv ? memw(mq[0]) : 32'h0);
            chk("rnd.req_v", 32'(mem_req_valid), 32'(e_rv));
            chk("rnd.addr",  mem_req_addr, m_fetch);
            keep = 1'b0;
            if (rv && pend.size() != 0) begin
                front = pend.pop_front();
                keep = (front.ep == epoch) && !redir;
            end
            if (redir) begin
                mq.delete();
                epoch = epoch + 1;
                m_fetch = rpc;
            end else begin
                if (e_iv && irr) void'(mq.pop_front());
                if (keep) mq.push_back(front.addr);
                if (e_rv && rdy) begin
                    pend.push_back('{addr: m_fetch, ep: epoch});
                    m_fetch = m_fetch + 32'd4;
                end
            end
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
